bcd_time_keeper: RTL and testbench

//  Parametrised hh:mm:ss BCD timekeeper; successor to the hh:mm counter. Adds seconds,

---
 rtl/bcd_time_keeper.sv | 239 +++++++++++++++++++++++
 tb/tb_bcd_time_keeper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_keeper.sv
// -----------------------------------------------------------------------------
// bcd_time_keeper
//   hh:mm:ss BCD timekeeper with an internal 1 s prescaler, up/down counting
//   with carry/borrow, validated time load, per-field adjust strobes, a 12h/24h
//   display view and a day-wrap pulse.
//
// Parameters
//   CLK_DIV   clk cycles per 1 s tick (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   en        1 = prescaler runs, 0 = time and prescaler frozen
//   up_down   1 = count up, 0 = count down (ticks and adjust strobes)
//   mode_12h  1 = disp_bcd in 12h format, 0 = 24h
//   load      1-cycle strobe: load load_bcd (24h packing)
//   load_bcd  {Ht[1:0],Hu[3:0],Mt[2:0],Mu[3:0],St[2:0],Su[3:0]}
//   adj_min   1-cycle strobe: step minutes, no carry into hours
//   adj_hour  1-cycle strobe: step hours
//   time_bcd  current time, 24h, same packing as load_bcd
//   disp_bcd  display time (24h or 12h), same packing
//   pm        1 when hours >= 12
//   sec_tick  1-cycle pulse on each applied 1 s tick
//   day_wrap  1-cycle pulse when a tick wraps the day in either direction
//   load_err  1-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module bcd_time_keeper #(
   parameter int CLK_DIV = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up_down,
   input  logic        mode_12h,
   input  logic        load,
   input  logic [19:0] load_bcd,
   input  logic        adj_min,
   input  logic        adj_hour,
   output logic [19:0] time_bcd,
   output logic [19:0] disp_bcd,
   output logic        pm,
   output logic        sec_tick,
   output logic        day_wrap,
   output logic        load_err
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   // Step a 00..59 field (tens 0..5, units 0..9). Returns {wrap, tens, units};
   // wrap is set when 59->00 (up) or 00->59 (down).
   function automatic logic [7:0] step60(input logic [2:0] t, input logic [3:0] u,
                                         input logic up);
      logic [2:0] tn;
      logic [3:0] un;
      logic       w;
      tn = t;
      un = u;
      w  = 1'b0;
      if (up) begin
         if (u == 4'd9) begin
            un = 4'd0;
            if (t == 3'd5) begin
               tn = 3'd0;
               w  = 1'b1;
            end else begin
               tn = t + 3'd1;
            end
         end else begin
            un = u + 4'd1;
         end
      end else begin
         if (u == 4'd0) begin
            un = 4'd9;
            if (t == 3'd0) begin
               tn = 3'd5;
               w  = 1'b1;
            end else begin
               tn = t - 3'd1;
            end
         end else begin
            un = u - 4'd1;
         end
      end
      return {w, tn, un};
   endfunction

   // Step the 00..23 hour field. Units wrap at 9, or at 3 when tens is 2.
   // Returns {wrap, tens, units}.
   function automatic logic [6:0] step24(input logic [1:0] t, input logic [3:0] u,
                                         input logic up);
      logic [1:0] tn;
      logic [3:0] un;
      logic       w;
      tn = t;
      un = u;
      w  = 1'b0;
      if (up) begin
         if (t == 2'd2 && u == 4'd3) begin
            tn = 2'd0;
            un = 4'd0;
            w  = 1'b1;
         end else if (u == 4'd9) begin
            un = 4'd0;
            tn = t + 2'd1;
         end else begin
            un = u + 4'd1;
         end
      end else begin
         if (t == 2'd0 && u == 4'd0) begin
            tn = 2'd2;
            un = 4'd3;
            w  = 1'b1;
         end else if (u == 4'd0) begin
            un = 4'd9;
            tn = t - 2'd1;
         end else begin
            un = u - 4'd1;
         end
      end
      return {w, tn, un};
   endfunction

   logic [19:0]      time_reg, time_next;
   logic [19:0]      disp_reg, disp_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic             pm_reg, pm_next;
   logic             tick_reg, tick_next;
   logic             wrap_reg, wrap_next;
   logic             err_reg, err_next;

   logic [7:0] sec_step;
   logic [7:0] min_step;
   logic [6:0] hour_step;
   logic       load_ok;

   assign sec_step  = step60(time_reg[6:4],   time_reg[3:0],   up_down);
   assign min_step  = step60(time_reg[13:11], time_reg[10:7],  up_down);
   assign hour_step = step24(time_reg[19:18], time_reg[17:14], up_down);

   assign load_ok = (load_bcd[19:18] <= 2'd2) &&
                    (load_bcd[17:14] <= 4'd9) &&
                    !((load_bcd[19:18] == 2'd2) && (load_bcd[17:14] > 4'd3)) &&
                    (load_bcd[13:11] <= 3'd5) &&
                    (load_bcd[10:7]  <= 4'd9) &&
                    (load_bcd[6:4]   <= 3'd5) &&
                    (load_bcd[3:0]   <= 4'd9);

   // Next-state time and prescaler. load beats the adjust strobes, which beat
   // the tick; a lower-priority event in the same cycle is simply dropped.
   always_comb begin
      time_next = time_reg;
      div_next  = div_reg;
      tick_next = 1'b0;
      wrap_next = 1'b0;
      err_next  = 1'b0;
      if (load) begin
         if (load_ok) begin
            time_next = load_bcd;
            div_next  = '0;
         end else begin
            err_next  = 1'b1;
         end
      end else if (adj_min || adj_hour) begin
         div_next        = '0;
         time_next[6:0]  = 7'd0;
         if (adj_min) begin
            time_next[13:7] = min_step[6:0];
         end
         if (adj_hour) begin
            time_next[19:14] = hour_step[5:0];
         end
      end else if (en) begin
         if (div_reg == DIV_MAX) begin
            div_next       = '0;
            tick_next      = 1'b1;
            time_next[6:0] = sec_step[6:0];
            if (sec_step[7]) begin
               time_next[13:7] = min_step[6:0];
               if (min_step[7]) begin
                  time_next[19:14] = hour_step[5:0];
                  wrap_next        = hour_step[6];
               end
            end
         end else begin
            div_next = div_reg + DIV_W'(1);
         end
      end
   end

   // Display view derived from next-state time so it updates on the same edge
   // as time_bcd. 12h hours: 00->12, 13..19 -> 01..07, 20..23 -> 08..11.
   always_comb begin
      disp_next = time_next;
      pm_next   = (time_next[19:18] == 2'd2) ||
                  ((time_next[19:18] == 2'd1) && (time_next[17:14] >= 4'd2));
      if (mode_12h) begin
         if (time_next[19:18] == 2'd0 && time_next[17:14] == 4'd0) begin
            disp_next[19:14] = {2'd1, 4'd2};
         end else if (time_next[19:18] == 2'd1 && time_next[17:14] >= 4'd3) begin
            disp_next[19:14] = {2'd0, time_next[17:14] - 4'd2};
         end else if (time_next[19:18] == 2'd2) begin
            if (time_next[17:14] <= 4'd1) begin
               disp_next[19:14] = {2'd0, time_next[17:14] + 4'd8};
            end else begin
               disp_next[19:14] = {2'd1, time_next[17:14] - 4'd2};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         time_reg <= '0;
         disp_reg <= '0;
         div_reg  <= '0;
         pm_reg   <= 1'b0;
         tick_reg <= 1'b0;
         wrap_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         time_reg <= time_next;
         disp_reg <= disp_next;
         div_reg  <= div_next;
         pm_reg   <= pm_next;
         tick_reg <= tick_next;
         wrap_reg <= wrap_next;
         err_reg  <= err_next;
      end
   end

   assign time_bcd = time_reg;
   assign disp_bcd = disp_reg;
   assign pm       = pm_reg;
   assign sec_tick = tick_reg;
   assign day_wrap = wrap_reg;
   assign load_err = err_reg;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_bcd_time_keeper
//   Directed bench for bcd_time_keeper with CLK_DIV=4. Inputs change 1 ns after
//   a rising edge; outputs are sampled at that same point, i.e. after the edge
//   has settled and well before the next one.
// -----------------------------------------------------------------------------
module tb_bcd_time_keeper;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        up_down;
   logic        mode_12h;
   logic        load;
   logic [19:0] load_bcd;
   logic        adj_min;
   logic        adj_hour;
   logic [19:0] time_bcd;
   logic [19:0] disp_bcd;
   logic        pm;
   logic        sec_tick;
   logic        day_wrap;
   logic        load_err;

   int total = 0;
   int bad   = 0;

   bcd_time_keeper #(.CLK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_down  (up_down),
      .mode_12h (mode_12h),
      .load     (load),
      .load_bcd (load_bcd),
      .adj_min  (adj_min),
      .adj_hour (adj_hour),
      .time_bcd (time_bcd),
      .disp_bcd (disp_bcd),
      .pm       (pm),
      .sec_tick (sec_tick),
      .day_wrap (day_wrap),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   // Pack two-digit BCD hour/minute/second bytes (e.g. 8'h23) into the port layout.
   function automatic logic [19:0] pack(input logic [7:0] h, input logic [7:0] m,
                                        input logic [7:0] s);
      return {h[5:4], h[3:0], m[6:4], m[3:0], s[6:4], s[3:0]};
   endfunction

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [19:0] v);
      load     = 1'b1;
      load_bcd = v;
      cyc(1);
      load     = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; up_down = 1'b1; mode_12h = 1'b0;
      load = 1'b0; load_bcd = '0; adj_min = 1'b0; adj_hour = 1'b0;

      // Reset state
      cyc(2);
      chk("rst_time", time_bcd, '0);
      chk("rst_disp", disp_bcd, '0);
      chk("rst_flags", {pm, sec_tick, day_wrap, load_err}, '0);

      // Count up from reset: first tick on the 4th edge
      rst = 1'b1; en = 1'b1; up_down = 1'b1;
      cyc(3);
      chk("pre_tick_time", time_bcd, pack(8'h00, 8'h00, 8'h00));
      chk("pre_tick_pulse", sec_tick, 1'b0);
      cyc(1);
      chk("tick1_time", time_bcd, pack(8'h00, 8'h00, 8'h01));
      chk("tick1_pulse", sec_tick, 1'b1);
      cyc(1);
      chk("tick1_pulse_clr", sec_tick, 1'b0);
      cyc(3);
      chk("tick2_time", time_bcd, pack(8'h00, 8'h00, 8'h02));
      $display("step: count up from reset");

      // Day wrap upward
      do_load(pack(8'h23, 8'h59, 8'h58));
      chk("load_up", time_bcd, pack(8'h23, 8'h59, 8'h58));
      cyc(4);
      chk("up_2359_59", time_bcd, pack(8'h23, 8'h59, 8'h59));
      chk("up_wrap_lo", day_wrap, 1'b0);
      cyc(4);
      chk("up_wrap_time", time_bcd, pack(8'h00, 8'h00, 8'h00));
      chk("up_wrap_hi", day_wrap, 1'b1);
      cyc(1);
      chk("up_wrap_clr", day_wrap, 1'b0);
      $display("step: day wrap up");

      // Day wrap downward
      up_down = 1'b0;
      do_load(pack(8'h00, 8'h00, 8'h00));
      cyc(4);
      chk("dn_wrap_time", time_bcd, pack(8'h23, 8'h59, 8'h59));
      chk("dn_wrap_hi", day_wrap, 1'b1);
      cyc(4);
      chk("dn_2359_58", time_bcd, pack(8'h23, 8'h59, 8'h58));
      chk("dn_wrap_lo", day_wrap, 1'b0);
      $display("step: day wrap down");

      // Rejected loads with time frozen
      en = 1'b0;
      do_load(pack(8'h24, 8'h00, 8'h00));
      chk("bad24_err", load_err, 1'b1);
      chk("bad24_time", time_bcd, pack(8'h23, 8'h59, 8'h58));
      cyc(1);
      chk("err_clr", load_err, 1'b0);
      do_load(pack(8'h12, 8'h60, 8'h00));
      chk("bad60_err", load_err, 1'b1);
      chk("bad60_time", time_bcd, pack(8'h23, 8'h59, 8'h58));
      do_load(pack(8'h09, 8'h15, 8'h6A));
      chk("bad6A_err", load_err, 1'b1);
      chk("bad6A_time", time_bcd, pack(8'h23, 8'h59, 8'h58));
      $display("step: rejected loads");

      // 12h display
      mode_12h = 1'b1;
      do_load(pack(8'h00, 8'h30, 8'h00));
      chk("h00_disp", disp_bcd, pack(8'h12, 8'h30, 8'h00));
      chk("h00_pm", pm, 1'b0);
      chk("h00_time", time_bcd, pack(8'h00, 8'h30, 8'h00));
      do_load(pack(8'h13, 8'h05, 8'h00));
      chk("h13_disp", disp_bcd, pack(8'h01, 8'h05, 8'h00));
      chk("h13_pm", pm, 1'b1);
      do_load(pack(8'h12, 8'h00, 8'h00));
      chk("h12_disp", disp_bcd, pack(8'h12, 8'h00, 8'h00));
      chk("h12_pm", pm, 1'b1);
      do_load(pack(8'h23, 8'h45, 8'h00));
      chk("h23_disp", disp_bcd, pack(8'h11, 8'h45, 8'h00));
      do_load(pack(8'h11, 8'h07, 8'h09));
      chk("h11_disp", disp_bcd, pack(8'h11, 8'h07, 8'h09));
      chk("h11_pm", pm, 1'b0);
      do_load(pack(8'h20, 8'h00, 8'h00));
      chk("h20_disp", disp_bcd, pack(8'h08, 8'h00, 8'h00));
      mode_12h = 1'b0;
      cyc(1);
      chk("mode24_disp", disp_bcd, pack(8'h20, 8'h00, 8'h00));
      chk("mode24_pm", pm, 1'b1);
      $display("step: 12h display");

      // Adjust strobes
      up_down = 1'b1;
      do_load(pack(8'h10, 8'h59, 8'h30));
      adj_min = 1'b1; cyc(1); adj_min = 1'b0;
      chk("adj_min_up", time_bcd, pack(8'h10, 8'h00, 8'h00));
      up_down = 1'b0;
      adj_hour = 1'b1; cyc(1); adj_hour = 1'b0;
      chk("adj_hour_dn", time_bcd, pack(8'h09, 8'h00, 8'h00));
      adj_hour = 1'b1; load = 1'b1; load_bcd = pack(8'h15, 8'h20, 8'h10);
      cyc(1);
      adj_hour = 1'b0; load = 1'b0;
      chk("load_beats_adj", time_bcd, pack(8'h15, 8'h20, 8'h10));
      up_down = 1'b1;
      do_load(pack(8'h23, 8'h59, 8'h45));
      adj_hour = 1'b1; cyc(1); adj_hour = 1'b0;
      chk("adj_hour_wrap", time_bcd, pack(8'h00, 8'h59, 8'h00));
      chk("adj_no_wrap", day_wrap, 1'b0);
      do_load(pack(8'h15, 8'h20, 8'h10));
      adj_min = 1'b1; adj_hour = 1'b1; en = 1'b1;
      cyc(1);
      adj_min = 1'b0; adj_hour = 1'b0;
      chk("adj_both", time_bcd, pack(8'h16, 8'h21, 8'h00));
      $display("step: adjust strobes");

      // Adjust cleared the prescaler; then en freeze mid-second
      cyc(3);
      chk("adj_div_hold", time_bcd, pack(8'h16, 8'h21, 8'h00));
      cyc(1);
      chk("adj_div_tick", time_bcd, pack(8'h16, 8'h21, 8'h01));
      cyc(2);
      en = 1'b0;
      cyc(5);
      chk("frozen", time_bcd, pack(8'h16, 8'h21, 8'h01));
      en = 1'b1;
      cyc(1);
      chk("resume_no_tick", time_bcd, pack(8'h16, 8'h21, 8'h01));
      cyc(1);
      chk("resume_tick", time_bcd, pack(8'h16, 8'h21, 8'h02));
      $display("step: prescaler hold");

      // Asynchronous reset mid-second
      cyc(1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_time", time_bcd, '0);
      chk("async_rst_disp", disp_bcd, '0);
      cyc(1);
      rst = 1'b1;
      cyc(3);
      chk("post_rst_no_tick", sec_tick, 1'b0);
      cyc(1);
      chk("post_rst_tick", time_bcd, pack(8'h00, 8'h00, 8'h01));
      $display("step: async reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
